// File: rtl/mainfsm_ctrl_if.sv
// Handshake/select bundle between the main control FSM and the multicycle ARM datapath.
// The master side is the controller; the slave side is the datapath and condition logic.
interface mainfsm_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Illegal, State
    );

    modport slave (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Illegal, State
    );
endinterface

// File: rtl/mainfsm_ctrl.sv
// Multicycle main control FSM for the ARM datapath: FETCH/DECODE/execute/writeback sequencing,
// stalling in memory states until MemReady. Emits raw RegW/MemW/Branch for downstream condition logic.
module mainfsm_ctrl (
    input  logic          clk,
    input  logic          reset,
    mainfsm_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd15
    } state_t;

    state_t     state;
    state_t     state_n;
    state_t     target;
    logic       in_fetch;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;

    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:    state_n = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_n = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_n = MEMADR;
                    2'b10:   state_n = BRANCH;
                    default: state_n = UNKNOWN;
                endcase
            end
            MEMADR:   state_n = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_n = bus.MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_n = bus.MemReady ? FETCH : MEMWRITE;
            EXECUTER: state_n = ALUWB;
            EXECUTEI: state_n = ALUWB;
            UNKNOWN:  state_n = UNKNOWN;
            default:  state_n = FETCH;
        endcase
    end

    // Reset folds into the target state so the registered outputs are decoded in one place.
    assign target = reset ? state_n : FETCH;

    always_ff @(posedge clk) begin
        state      <= target;
        in_fetch   <= 1'b0;
        adr_src    <= 1'b0;
        alu_src_a  <= '0;
        alu_src_b  <= '0;
        result_src <= '0;
        alu_op     <= 1'b0;
        reg_w      <= 1'b0;
        mem_w      <= 1'b0;
        branch     <= 1'b0;
        illegal    <= 1'b0;
        case (target)
            FETCH: begin
                in_fetch   <= 1'b1;
                alu_src_a  <= 2'b01;
                alu_src_b  <= 2'b10;
                result_src <= 2'b10;
            end
            DECODE: begin
                alu_src_a  <= 2'b01;
                alu_src_b  <= 2'b10;
                result_src <= 2'b10;
            end
            MEMADR:   alu_src_b <= 2'b01;
            MEMREAD:  adr_src   <= 1'b1;
            MEMWB: begin
                result_src <= 2'b01;
                reg_w      <= 1'b1;
            end
            MEMWRITE: begin
                adr_src <= 1'b1;
                mem_w   <= 1'b1;
            end
            EXECUTER: alu_op <= 1'b1;
            EXECUTEI: begin
                alu_src_b <= 2'b01;
                alu_op    <= 1'b1;
            end
            ALUWB:    reg_w <= 1'b1;
            BRANCH: begin
                alu_src_a  <= 2'b10;
                alu_src_b  <= 2'b01;
                result_src <= 2'b10;
                branch     <= 1'b1;
            end
            UNKNOWN:  illegal <= 1'b1;
            default: ;
        endcase
    end

    // IR load and PC advance follow the memory handshake so the PC moves once per fetch.
    assign bus.IRWrite   = in_fetch & bus.MemReady;
    assign bus.NextPC    = in_fetch & bus.MemReady;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.ALUOp     = alu_op;
    assign bus.RegW      = reg_w;
    assign bus.MemW      = mem_w;
    assign bus.Branch    = branch;
    assign bus.Illegal   = illegal;
    assign bus.State     = state;
endmodule

// File: tb/tb_mainfsm_ctrl.sv
// Scoreboard bench for mainfsm_ctrl: a reference model pushes expected state/outputs each cycle,
// which are popped and compared against the DUT mid-cycle.
module tb_mainfsm_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   irw_count;
    int   memw_count;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] o;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_state;

    mainfsm_ctrl_if bus ();

    mainfsm_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic rst_n,
                                              input logic [1:0] op, input logic [5:0] f,
                                              input logic mr);
        if (!rst_n) return 4'd0;
        case (s)
            4'd0: return mr ? 4'd1 : 4'd0;
            4'd1: begin
                if (op == 2'b01) return 4'd2;
                if (op == 2'b10) return 4'd9;
                if (op == 2'b11) return 4'd15;
                return f[5] ? 4'd7 : 4'd6;
            end
            4'd2:  return f[0] ? 4'd3 : 4'd5;
            4'd3:  return mr ? 4'd4 : 4'd3;
            4'd5:  return mr ? 4'd0 : 4'd5;
            4'd6, 4'd7: return 4'd8;
            4'd15: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    // {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Illegal}
    function automatic logic [13:0] exp_outs(input logic [3:0] s, input logic mr);
        logic irw, adr, aop, rw, mw, br, ill;
        logic [1:0] sa, sb, rs;
        irw = 0; adr = 0; aop = 0; rw = 0; mw = 0; br = 0; ill = 0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (s)
            4'd0:  begin irw = mr; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            4'd2:  sb = 2'b01;
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  aop = 1;
            4'd7:  begin sb = 2'b01; aop = 1; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
            4'd15: ill = 1;
            default: ;
        endcase
        return {irw, irw, adr, sa, sb, rs, aop, rw, mw, br, ill};
    endfunction

    // Called #1 after a rising edge: drive inputs, push expectation, compare at negedge, advance model.
    task automatic cycle(input logic rst_n, input logic [1:0] op, input logic [5:0] f, input logic mr);
        exp_t e;
        exp_t got;
        reset        = rst_n;
        bus.Op       = op;
        bus.Funct    = f;
        bus.MemReady = mr;
        e.st = m_state;
        e.o  = exp_outs(m_state, mr);
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        check_eq($sformatf("state@%0d", got.st), {28'd0, bus.State}, {28'd0, got.st});
        check_eq($sformatf("outs@%0d", got.st),
                 {18'd0, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW, bus.Branch, bus.Illegal},
                 {18'd0, got.o});
        if (bus.IRWrite === 1'b1) irw_count++;
        if (bus.MemW === 1'b1) memw_count++;
        @(posedge clk);
        m_state = model_next(m_state, rst_n, op, f, mr);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset        = 1'b0;
        bus.Op       = 2'b00;
        bus.Funct    = 6'd0;
        bus.MemReady = 1'b1;
        @(posedge clk);
        m_state = 4'd0;
        #1;

        // reset held two cycles, then released with MemReady high
        cycle(0, 2'b00, 6'd0, 1);
        cycle(0, 2'b00, 6'd0, 1);
        // data-proc register: 0,1,6,8
        repeat (4) cycle(1, 2'b00, 6'b000000, 1);
        // data-proc immediate: 0,1,7,8
        repeat (4) cycle(1, 2'b00, 6'b100000, 1);

        // load with 3-cycle MEMREAD stall: 0,1,2,3,3,3,3,4
        repeat (3) cycle(1, 2'b01, 6'b000001, 1);
        repeat (3) cycle(1, 2'b01, 6'b000001, 0);
        repeat (2) cycle(1, 2'b01, 6'b000001, 1);
        check_eq("load_back_to_fetch", {28'd0, bus.State}, 32'd0);

        // store with 2-cycle FETCH stall and 2-cycle MEMWRITE stall
        irw_count  = 0;
        memw_count = 0;
        repeat (2) cycle(1, 2'b01, 6'b000000, 0);
        repeat (3) cycle(1, 2'b01, 6'b000000, 1);
        repeat (2) cycle(1, 2'b01, 6'b000000, 0);
        cycle(1, 2'b01, 6'b000000, 1);
        check_eq("store_irwrite_pulses", irw_count, 32'd1);
        check_eq("store_memw_cycles", memw_count, 32'd3);

        // branch: 0,1,9
        repeat (3) cycle(1, 2'b10, 6'd0, 1);

        // reset while stalled in MEMWRITE
        repeat (3) cycle(1, 2'b01, 6'b000000, 1);
        cycle(1, 2'b01, 6'b000000, 0);
        cycle(0, 2'b01, 6'b000000, 0);
        cycle(1, 2'b01, 6'b000000, 0);
        check_eq("reset_mid_stall_memw", {31'd0, bus.MemW}, 32'd0);

        // undefined op parks in UNKNOWN until reset
        repeat (6) cycle(1, 2'b11, 6'd0, 1);
        check_eq("unknown_held", {28'd0, bus.State}, 32'd15);
        cycle(0, 2'b11, 6'd0, 1);
        cycle(1, 2'b00, 6'd0, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        check_eq("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
